// File: rtl/wave_shaper.sv
// -----------------------------------------------------------------------------
// wave_shaper
//
// Converts the oscillator bank's per-voice phase counters into unsigned 8-bit
// waveform samples for the signal mixer. Each sample-rate strobe starts a
// sweep over all voices. For each voice the sweep:
//   - snapshots the voice's counter and limit,
//   - runs one shared 8-step restoring divider to get the phase
//     p = floor(count*256 / (lim+1)),
//   - shapes p into a square, saw or triangle sample,
//   - writes the result into a shadow bank.
// After the last voice, the whole shadow bank is copied to the outputs in a
// single cycle, so the mixer never sees a half-updated set of samples.
//
// Per-voice timing: 1 LOAD + 8 DIV + 1 WRITE = 10 cycles, so a 12-voice
// sweep takes 120 cycles.
//
// Ports
//   clk        system clock
//   n_rst      asynchronous, active-high reset
//   start_i    one-cycle sample-rate strobe; starts a sweep when idle
//   modekey_i  one-cycle pulse; steps the mode square -> saw -> triangle
//   counts_i   per-voice oscillator counters   (NVOICE x CNTW)
//   lims_i     per-voice counter wrap limits   (NVOICE x CNTW)
//   samples_o  per-voice shaped samples        (NVOICE x 8)
//   mode_o     current mode: 0 square, 1 saw, 2 triangle
//   busy_o     high while a sweep is running
//   done_o     one-cycle pulse in the cycle the new samples appear
// -----------------------------------------------------------------------------
module wave_shaper #(
    parameter int NVOICE = 12,
    parameter int CNTW   = 16
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start_i,
    input  logic                          modekey_i,
    input  logic [NVOICE-1:0][CNTW-1:0]   counts_i,
    input  logic [NVOICE-1:0][CNTW-1:0]   lims_i,
    output logic [NVOICE-1:0][7:0]        samples_o,
    output logic [1:0]                    mode_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int IW = (NVOICE > 1) ? $clog2(NVOICE) : 1;

    localparam logic [1:0] MODE_SQUARE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_WRITE
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                    state_q,      state_d;
    logic [1:0]                mode_q,       mode_d;
    logic [1:0]                sweep_mode_q, sweep_mode_d;
    logic [IW-1:0]             idx_q,        idx_d;

    // Divider: the remainder is always below the divisor (lim+1 <= 2^CNTW),
    // so CNTW+1 bits are enough to hold it between iterations.
    logic [CNTW:0]             rem_q,        rem_d;
    logic [CNTW:0]             dvs_q,        dvs_d;
    logic [7:0]                quo_q,        quo_d;
    logic [2:0]                iter_q,       iter_d;
    logic                      clamp_q,      clamp_d;

    logic [NVOICE-1:0][7:0]    shadow_q,     shadow_d;
    logic [NVOICE-1:0][7:0]    samples_q,    samples_d;
    logic                      done_q,       done_d;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic [CNTW-1:0]           count_sel;
    logic [CNTW-1:0]           lim_sel;
    logic [CNTW+1:0]           rem_shift;
    logic [CNTW:0]             rem_sub;
    logic                      rem_ge;
    logic [7:0]                phase;
    logic [7:0]                shaped;
    logic [NVOICE-1:0][7:0]    commit_vec;

    assign count_sel = counts_i[idx_q];
    assign lim_sel   = lims_i[idx_q];

    // The dividend is count*256, i.e. count followed by eight zero bits.
    // When count <= lim, count < lim+1, so the upper quotient bits are zero.
    // Seeding the remainder with count and shifting in eight zeros therefore
    // yields the full 8-bit quotient in eight steps.
    assign rem_shift = {rem_q, 1'b0};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});

    // Only used when rem_ge holds. In that case rem_shift < 2*divisor, so the
    // low CNTW+1 bits of the difference are exact.
    assign rem_sub   = rem_shift[CNTW:0] - dvs_q;

    // A counter past its limit (e.g. the limit was lowered under a running
    // oscillator) is treated as the end of the period.
    assign phase = clamp_q ? 8'hFF : quo_q;

    // Shaping. The test p < 128 is just !p[7], and 255-p is ~p for 8 bits,
    // so the triangle needs no subtractor.
    always_comb begin
        shaped = phase;
        case (sweep_mode_q)
            MODE_SQUARE: shaped = phase[7] ? 8'h00 : 8'hFF;
            MODE_SAW:    shaped = phase;
            MODE_TRI:    shaped = phase[7] ? {~phase[6:0], 1'b0}
                                           : { phase[6:0], 1'b0};
            default:     shaped = phase;
        endcase
    end

    // Commit image: the shadow bank with the voice being written this cycle
    // already substituted, so the last voice lands in the same commit.
    generate
        for (genvar gi = 0; gi < NVOICE; gi++) begin : g_commit
            assign commit_vec[gi] = (idx_q == IW'(gi)) ? shaped : shadow_q[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        sweep_mode_d = sweep_mode_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        quo_d        = quo_q;
        iter_d       = iter_q;
        clamp_d      = clamp_q;
        shadow_d     = shadow_q;
        samples_d    = samples_q;
        done_d       = 1'b0;

        // The mode key works in every state. A running sweep keeps using its
        // own latched copy of the mode.
        if (modekey_i) begin
            mode_d = (mode_q >= MODE_TRI) ? MODE_SQUARE : mode_q + 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                // mode_q is the value from before any simultaneous key press.
                if (start_i) begin
                    sweep_mode_d = mode_q;
                    idx_d        = '0;
                    state_d      = ST_LOAD;
                end
            end

            ST_LOAD: begin
                rem_d   = {1'b0, count_sel};
                dvs_d   = {1'b0, lim_sel} + (CNTW+1)'(1);
                quo_d   = '0;
                iter_d  = '0;
                clamp_d = (count_sel > lim_sel);
                state_d = ST_DIV;
            end

            ST_DIV: begin
                rem_d  = rem_ge ? rem_sub : rem_shift[CNTW:0];
                quo_d  = {quo_q[6:0], rem_ge};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                shadow_d[idx_q] = shaped;
                if (idx_q == IW'(NVOICE-1)) begin
                    samples_d = commit_vec;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_LOAD;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // Reset aborts a sweep outright. The committed samples are cleared along
    // with the shadow bank, so no partial result can ever reach the mixer.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_SQUARE;
            sweep_mode_q <= MODE_SQUARE;
            idx_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            quo_q        <= '0;
            iter_q       <= '0;
            clamp_q      <= 1'b0;
            shadow_q     <= '0;
            samples_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            sweep_mode_q <= sweep_mode_d;
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            quo_q        <= quo_d;
            iter_q       <= iter_d;
            clamp_q      <= clamp_d;
            shadow_q     <= shadow_d;
            samples_q    <= samples_d;
            done_q       <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign samples_o = samples_q;
    assign mode_o    = mode_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;

endmodule

// File: tb/tb_wave_shaper.sv
// -----------------------------------------------------------------------------
// tb_wave_shaper
//
// Scoreboard bench for wave_shaper. Each sweep pushes the expected sample set
// when start is driven. The expected values come from the arithmetic
// definition of phase and shape. A monitor pops and compares the front entry
// whenever done is seen. The main flow also checks:
//   - reset state and reset mid-sweep,
//   - mode stepping, including a key press on the same cycle as start,
//   - sweep latency and busy length,
//   - that a start arriving while busy is ignored.
// -----------------------------------------------------------------------------
module tb_wave_shaper;

    localparam int NV = 12;
    localparam int CW = 16;

    logic                   clk = 1'b0;
    logic                   n_rst = 1'b1;
    logic                   start_i = 1'b0;
    logic                   modekey_i = 1'b0;
    logic [NV-1:0][CW-1:0]  counts_i = '0;
    logic [NV-1:0][CW-1:0]  lims_i = '0;
    logic [NV-1:0][7:0]     samples_o;
    logic [1:0]             mode_o;
    logic                   busy_o;
    logic                   done_o;

    wave_shaper #(.NVOICE(NV), .CNTW(CW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start_i   (start_i),
        .modekey_i (modekey_i),
        .counts_i  (counts_i),
        .lims_i    (lims_i),
        .samples_o (samples_o),
        .mode_o    (mode_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int dones       = 0;
    int exp_dones   = 0;
    logic           prev_done = 1'b0;
    logic [1:0]     mdl_mode  = 2'd0;
    logic [NV*8-1:0] sb[$];
    logic [NV*8-1:0] last_exp = '0;
    logic [NV*8-1:0] mon_exp;

    // Operand tables; each sweep rotates through them so each voice sees
    // several patterns. Includes lim=0, a full-range limit and clamp cases.
    int cnt_tab[NV] = '{19124, 0, 38223, 9556, 40000, 5, 0, 65535, 1000, 12345, 65535, 300};
    int lim_tab[NV] = '{38223, 38223, 38223, 38223, 38223, 0, 0, 65535, 1999, 24690, 0, 299};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int phase_of(input int c, input int l);
        if (c > l) return 255;
        return (c * 256) / (l + 1);
    endfunction

    function automatic logic [7:0] shape_of(input int p, input logic [1:0] m);
        case (m)
            2'd0:    return (p < 128) ? 8'd255 : 8'd0;
            2'd1:    return 8'(p);
            2'd2:    return (p < 128) ? 8'(p * 2) : 8'((255 - p) * 2);
            default: return 8'(p);
        endcase
    endfunction

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return (m == 2'd2) ? 2'd0 : m + 2'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input int rot);
        for (int v = 0; v < NV; v++) begin
            counts_i[v] = CW'(cnt_tab[(v + rot) % NV]);
            lims_i[v]   = CW'(lim_tab[(v + rot) % NV]);
        end
    endtask

    function automatic logic [NV*8-1:0] expected_vec(input logic [1:0] m);
        logic [NV*8-1:0] e;
        e = '0;
        for (int v = 0; v < NV; v++)
            e[v*8 +: 8] = shape_of(phase_of(int'(counts_i[v]), int'(lims_i[v])), m);
        return e;
    endfunction

    task automatic key_pulse();
        modekey_i = 1'b1;
        tick();
        modekey_i = 1'b0;
        mdl_mode = next_mode(mdl_mode);
        check("mode_step", 32'(mode_o), 32'(mdl_mode));
        $display("modekey: mode=%0d", mode_o);
    endtask

    task automatic set_mode(input logic [1:0] m);
        for (int k = 0; k < 3 && mdl_mode != m; k++) key_pulse();
    endtask

    // One sweep.
    //   key_same   : press modekey on the same cycle as start.
    //   disturb_at : after that many busy cycles, alter voices 0..2 (already
    //                snapshotted) and press modekey.
    //   restart_at : inject a start pulse while busy; it must be ignored.
    //   abort_at   : assert reset mid-sweep.
    task automatic run_sweep(input int rot, input bit key_same, input int disturb_at,
                             input int restart_at, input int abort_at);
        int  n;
        bit  aborted;
        logic [NV*8-1:0] e;
        n = 0;
        aborted = 1'b0;
        set_inputs(rot);
        e = expected_vec(mdl_mode);
        sb.push_back(e);
        start_i   = 1'b1;
        modekey_i = key_same;
        tick();
        start_i   = 1'b0;
        modekey_i = 1'b0;
        if (key_same) begin
            mdl_mode = next_mode(mdl_mode);
            check("mode_with_start", 32'(mode_o), 32'(mdl_mode));
        end
        while (busy_o && n < 300) begin
            n++;
            start_i   = (n == restart_at);
            modekey_i = 1'b0;
            if (n == disturb_at) begin
                for (int v = 0; v < 3; v++) counts_i[v] = ~counts_i[v];
                modekey_i = 1'b1;
                mdl_mode  = next_mode(mdl_mode);
            end
            if (n == abort_at) begin
                for (int v = 0; v < NV; v++)
                    check($sformatf("stable_mid[%0d]", v), 32'(samples_o[v]), 32'(last_exp[v*8 +: 8]));
                n_rst = 1'b1;
                #1;
                check("rst_samples_any", 32'(|samples_o), 32'd0);
                check("rst_mode", 32'(mode_o), 32'd0);
                check("rst_busy", 32'(busy_o), 32'd0);
                check("rst_done", 32'(done_o), 32'd0);
                aborted = 1'b1;
                break;
            end
            tick();
        end
        start_i   = 1'b0;
        modekey_i = 1'b0;
        if (aborted) begin
            sb.delete();
            last_exp = '0;
            mdl_mode = 2'd0;
            tick();
            tick();
            n_rst = 1'b0;
            $display("sweep rot=%0d aborted by reset after %0d cycles", rot, n);
        end else begin
            check("busy_cycles", 32'(n), 32'd120);
            check("done_at_E120", 32'(done_o), 32'd1);
            check("busy_at_done", 32'(busy_o), 32'd0);
            check("mode_after", 32'(mode_o), 32'(mdl_mode));
            exp_dones++;
            last_exp = e;
        end
    endtask

    // Monitor: compare every committed sample set against the scoreboard.
    always @(negedge clk) begin
        if (done_o) begin
            dones++;
            check("done_width", 32'(prev_done), 32'd0);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                for (int v = 0; v < NV; v++)
                    check($sformatf("sample[%0d]", v), 32'(samples_o[v]), 32'(mon_exp[v*8 +: 8]));
                $display("commit %0d: s0=%0d s1=%0d s2=%0d s3=%0d s4=%0d s5=%0d",
                         dones, samples_o[0], samples_o[1], samples_o[2],
                         samples_o[3], samples_o[4], samples_o[5]);
            end
        end
        prev_done = done_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        n_rst = 1'b1;
        tick(); tick(); tick();
        check("rst0_samples_any", 32'(|samples_o), 32'd0);
        check("rst0_mode", 32'(mode_o), 32'd0);
        check("rst0_busy", 32'(busy_o), 32'd0);
        check("rst0_done", 32'(done_o), 32'd0);
        n_rst = 1'b0;
        tick();

        // Mode wraps after three presses
        key_pulse(); key_pulse(); key_pulse();

        // Saw, with mid-sweep input/mode disturbance and an ignored restart
        set_mode(2'd1);
        run_sweep(0, 1'b0, 30, 60, 0);
        set_mode(2'd1);
        run_sweep(3, 1'b0, 0, 0, 0);

        // Square, the second start lands on the done cycle
        set_mode(2'd0);
        run_sweep(0, 1'b0, 0, 0, 0);
        run_sweep(3, 1'b0, 0, 0, 0);

        // Triangle
        set_mode(2'd2);
        run_sweep(0, 1'b0, 0, 0, 0);
        run_sweep(4, 1'b0, 0, 0, 0);

        // modekey and start together from square: sweep is square, mode -> 1
        set_mode(2'd0);
        run_sweep(1, 1'b1, 0, 0, 0);

        // Starts every 256 cycles
        for (int k = 0; k < 3; k++) begin
            run_sweep(k + 5, 1'b0, 0, 0, 0);
            repeat (256 - 121) tick();
        end

        // Reset mid-sweep: no done until a new start
        set_mode(2'd1);
        run_sweep(6, 1'b0, 0, 0, 50);
        repeat (300) tick();
        check("no_done_after_rst", 32'(dones), 32'(exp_dones));

        // Recovery
        run_sweep(2, 1'b0, 0, 0, 0);
        repeat (3) tick();
        check("done_count", 32'(dones), 32'(exp_dones));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wave_shaper.md
# wave_shaper

Turns the 12 oscillator phase counters into 12 unsigned 8-bit waveform samples (square, sawtooth or triangle) for the signal mixer. It sits between the oscillator bank and the signal mixer. Once per sample period, triggered by the sample-rate strobe, it walks the voices through one shared shift-subtract divider. All 12 samples then commit to the outputs together.

## Interface
- NVOICE, 12, number of voices
- CNTW, 16, oscillator counter / limit width
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle sample-rate strobe; begins a sweep
- modekey  in  1  one-cycle pulse; advances waveform mode
- counts  in  NVOICE x CNTW  current oscillator counter per voice
- lims  in  NVOICE x CNTW  frequency divider limit per voice (counter wraps after lim)
- samples  out  NVOICE x 8  shaped samples, to the mixer
- mode  out  2  current mode: 0 square, 1 saw, 2 triangle
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when samples update

## Operation
- Mode register: 0→1→2→0 on each modekey pulse. Value 3 is never reached.
- Sweep FSM states: IDLE, LOAD, DIV, WRITE.
  - IDLE: on start, latch mode into sweep_mode, set voice index i=0, go to LOAD.
  - LOAD: snapshot counts[i] and lims[i]. Clear the divider. Go to DIV.
  - DIV: 8-cycle restoring division producing phase p = floor(count·256 / (lim+1)).
    - Dividend is 24 bit; divisor is 17 bit.
    - After 8 iterations, go to WRITE.
  - WRITE: write shaped(p) into shadow[i].
    - If i = NVOICE-1: commit all shadow entries (including this one) to samples, pulse done, go to IDLE.
    - Otherwise: i++ and go to LOAD.
- Snapshot clamp: if count > lim, force p = 255.
- lim = 0: divisor is 1, so p = count clamped to 255.
- Shaping, all 8-bit unsigned:
  - Square: p < 128 → 255, else 0.
  - Saw: p.
  - Triangle: p < 128 → p<<1; else (255−p)<<1. Range 0..254.
- start while busy: ignored, with no queuing.
- modekey and start in the same cycle: both are honoured. The sweep uses the pre-advance mode; the mode output shows the new value.
- Mode changes during a sweep do not affect that sweep.

## Timing
- Reset state:
  - samples all 0, mode 0, busy 0, done 0.
  - FSM in IDLE; shadow and divider cleared.
- Reset mid-sweep aborts immediately. No partial commit.
- Edge E0 samples start. busy is high from after E0 through the cycle ending at E120.
- Voice i:
  - LOAD at edge E(1+10i).
  - DIV iterations at E(2+10i)..E(9+10i).
  - WRITE at E(10+10i).
- Commit at E120. samples change and done=1 in the cycle after E120. done lasts exactly one cycle; busy=0 at the same time.
- Sweep length: 120 cycles, under the 256-cycle sample period, so every start is serviced.
- samples are stable between commits; the mixer sees no partial update.
- A new start is accepted on the cycle done is high, since the FSM is already in IDLE.

## Test plan
- Reset: assert n_rst mid-sweep (~E50) → samples all 0, mode=0, busy=0, done=0. Release → no done until the next start.
- Saw: mode=1, lims[0]=38223.
  - counts[0]=19124 → samples[0]=128.
  - counts 0 → 0.
  - counts 38223 → 255.
  - Inputs change between E0 and E120 → committed values are unaffected for already-snapshotted voices.
- Square, same inputs: mode=0 → 19124 gives 0, 0 gives 255, 9556 gives 255.
- Triangle: mode=2, lim=38223.
  - count 9556 (p=64) → 128.
  - count 19124 (p=128) → 254.
  - count 38223 (p=255) → 0.
  - count 40000 (clamp, p=255) → 0.
- Mode/handshake, starting from mode 0:
  - 3 modekey pulses → mode returns to 0.
  - modekey and start in the same cycle from mode 0 → mode output 1, sweep shapes as square.
- Latency: start at E0 → done exactly one cycle after E120, busy high for 120 cycles. A second start at E60 is ignored (one done only). Back-to-back starts every 256 cycles → one done per start.
